// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: redirect priority, trap/EPC capture, misalign trap, boot bubble.
// Define PC_SEQ_RAS_EN to build the return-address stack used by call/ret.
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     INSTR_BYTES  = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_off_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            trap_i,
    input  logic            trap_ret_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] epc_o,
    output logic            misalign_o,
    output logic            ras_err_o
);
    typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;

    localparam logic [XLEN-1:0] AlignMask = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] Incr      = XLEN'(INSTR_BYTES);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d, target;
    logic            misalign_q, misalign_d, ras_err_q, ras_err_d, redirect;
    logic            ret_req, call_req, ras_empty, ras_pop, ras_push;
    logic [XLEN-1:0] ras_top;

    assign pc_plus_o = pc_q + Incr;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = 1'b0;
        ras_err_d  = 1'b0;
        ras_pop    = 1'b0;
        ras_push   = 1'b0;
        redirect   = 1'b0;
        target     = pc_q;
        unique case (state_q)
            StBoot, StFlush: state_d = StRun;
            StRun: begin
                if (trap_i) begin
                    pc_d    = TRAP_VECTOR;
                    epc_d   = pc_q;
                    state_d = StFlush;
                end else begin
                    ras_push = call_req;
                    if (trap_ret_i) begin
                        redirect = 1'b1;
                        target   = epc_q;
                    end else if (ret_req) begin
                        // Underflowing ret falls back to the sequential path.
                        if (ras_empty) begin
                            ras_err_d = 1'b1;
                            pc_d      = pc_plus_o;
                        end else begin
                            ras_pop = 1'b1;
                            pc_d    = ras_top;
                        end
                    end else if (jump_i) begin
                        redirect = 1'b1;
                        target   = jump_target_i;
                    end else if (branch_taken_i) begin
                        redirect = 1'b1;
                        target   = pc_q + branch_off_i;
                    end else if (!stall_i) begin
                        pc_d = pc_plus_o;
                    end
                    if (redirect) begin
                        if ((target & AlignMask) != '0) begin
                            pc_d       = TRAP_VECTOR;
                            epc_d      = pc_q;
                            misalign_d = 1'b1;
                            state_d    = StFlush;
                        end else begin
                            pc_d = target;
                        end
                    end
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StBoot;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            misalign_q <= 1'b0;
            ras_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            misalign_q <= misalign_d;
            ras_err_q  <= ras_err_d;
        end
    end

`ifdef PC_SEQ_RAS_EN
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned DepW = $clog2(RAS_DEPTH + 1);

    // Circular buffer: ptr_q is the next write slot, so a full push overwrites the oldest.
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PtrW-1:0] ptr_q, top_idx;
    logic [DepW-1:0] depth_q;

    assign ret_req   = ret_i;
    assign call_req  = call_i;
    assign top_idx   = ptr_q - PtrW'(1);
    assign ras_empty = (depth_q == '0);
    assign ras_top   = ras_q[top_idx];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            depth_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
        end else if (ras_pop && ras_push) begin
            ras_q[top_idx] <= pc_plus_o;
        end else if (ras_pop) begin
            ptr_q   <= top_idx;
            depth_q <= depth_q - DepW'(1);
        end else if (ras_push) begin
            ras_q[ptr_q] <= pc_plus_o;
            ptr_q        <= ptr_q + PtrW'(1);
            if (depth_q != DepW'(RAS_DEPTH)) depth_q <= depth_q + DepW'(1);
        end
    end
`else
    logic unused_ras;

    assign ret_req    = 1'b0;
    assign call_req   = 1'b0;
    assign ras_empty  = 1'b1;
    assign ras_top    = '0;
    assign unused_ras = call_i ^ ret_i ^ ras_pop ^ ras_push;
`endif

    assign pc_o       = pc_q;
    assign pc_valid_o = (state_q == StRun);
    assign epc_o      = epc_q;
    assign misalign_o = misalign_q;
    assign ras_err_o  = ras_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, RAS sequence, randomized run vs reference model.
module tb_pc_sequencer;
    localparam logic [31:0] ResetVec = 32'h0000_0000;
    localparam logic [31:0] TrapVec  = 32'h0000_0100;
    localparam int          RasDepth = 4;
`ifdef PC_SEQ_RAS_EN
    localparam bit RasEn = 1'b1;
`else
    localparam bit RasEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, stall, branch_taken, jump, trap, trap_ret, call, ret;
    logic [31:0] branch_off, jump_target;
    logic [31:0] pc, pc_plus, epc;
    logic        pc_valid, misalign, ras_err;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .stall_i        (stall),
        .branch_taken_i (branch_taken),
        .branch_off_i   (branch_off),
        .jump_i         (jump),
        .jump_target_i  (jump_target),
        .trap_i         (trap),
        .trap_ret_i     (trap_ret),
        .call_i         (call),
        .ret_i          (ret),
        .pc_o           (pc),
        .pc_plus_o      (pc_plus),
        .pc_valid_o     (pc_valid),
        .epc_o          (epc),
        .misalign_o     (misalign),
        .ras_err_o      (ras_err)
    );

    typedef struct {
        bit          rst_n;
        bit          stall;
        bit          br;
        logic [31:0] off;
        bit          jmp;
        logic [31:0] tgt;
        bit          trap;
        bit          tret;
        bit          call;
        bit          ret;
    } in_t;

    typedef struct {
        in_t         in;
        logic [31:0] pc;
        bit          valid;
        logic [31:0] epc;
        bit          mis;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    // Reference model state
    logic [31:0] m_pc, m_epc;
    bit          m_valid, m_mis, m_err;
    logic [31:0] m_ras[$];

    function automatic in_t mk(bit r, bit s, bit b, logic [31:0] o, bit j, logic [31:0] t,
                               bit tr, bit trt);
        in_t x;
        x.rst_n = r; x.stall = s; x.br = b; x.off = o; x.jmp = j; x.tgt = t;
        x.trap = tr; x.tret = trt; x.call = 1'b0; x.ret = 1'b0;
        return x;
    endfunction

    task automatic add(in_t in, logic [31:0] p, bit v, logic [31:0] e, bit m);
        vec_t x;
        x.in = in; x.pc = p; x.valid = v; x.epc = e; x.mis = m;
        vq.push_back(x);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // An invalid fetch cycle (boot or post-trap) always becomes valid next with pc held.
    task automatic model_step(in_t in);
        logic [31:0] seq, tgt, nxt;
        bit          have;
        if (!in.rst_n) begin
            m_pc = ResetVec; m_epc = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_err = 1'b0;
            m_ras.delete();
            return;
        end
        m_mis = 1'b0;
        m_err = 1'b0;
        if (!m_valid) begin
            m_valid = 1'b1;
            return;
        end
        if (in.trap) begin
            m_epc = m_pc; m_pc = TrapVec; m_valid = 1'b0;
            return;
        end
        seq = m_pc + 32'd4;
        have = 1'b0;
        tgt = 32'h0;
        nxt = m_pc;
        if (in.tret) begin
            have = 1'b1; tgt = m_epc;
        end else if (RasEn && in.ret) begin
            if (m_ras.size() == 0) begin
                m_err = 1'b1; nxt = seq;
            end else begin
                nxt = m_ras.pop_back();
            end
        end else if (in.jmp) begin
            have = 1'b1; tgt = in.tgt;
        end else if (in.br) begin
            have = 1'b1; tgt = m_pc + in.off;
        end else if (!in.stall) begin
            nxt = seq;
        end
        if (RasEn && in.call) begin
            m_ras.push_back(seq);
            if (m_ras.size() > RasDepth) m_ras.delete(0);
        end
        if (have) begin
            if ((tgt % 4) != 0) begin
                m_epc = m_pc; m_pc = TrapVec; m_valid = 1'b0; m_mis = 1'b1;
                return;
            end
            nxt = tgt;
        end
        m_pc = nxt;
    endtask

    task automatic step(in_t in);
        rst_n = in.rst_n; stall = in.stall; branch_taken = in.br; branch_off = in.off;
        jump = in.jmp; jump_target = in.tgt; trap = in.trap; trap_ret = in.tret;
        call = in.call; ret = in.ret;
        model_step(in);
        @(posedge clk);
        #1;
        check("model_pc", pc, m_pc);
        check("model_pc_plus", pc_plus, m_pc + 32'd4);
        check("model_pc_valid", 32'(pc_valid), 32'(m_valid));
        check("model_epc", epc, m_epc);
        check("model_misalign", 32'(misalign), 32'(m_mis));
        check("model_ras_err", 32'(ras_err), 32'(m_err));
    endtask

    initial begin
        in_t rs, id, x;
        rs = mk(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        id = mk(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);

        add(rs, 32'h0, 0, 32'h0, 0);
        add(rs, 32'h0, 0, 32'h0, 0);
        add(id, 32'h0, 1, 32'h0, 0);
        add(id, 32'h4, 1, 32'h0, 0);
        add(id, 32'h8, 1, 32'h0, 0);
        add(id, 32'hC, 1, 32'h0, 0);
        add(id, 32'h10, 1, 32'h0, 0);
        add(mk(1, 1, 1, 32'hFFFF_FFF8, 1, 32'h200, 0, 0), 32'h200, 1, 32'h0, 0);
        add(mk(1, 0, 1, 32'hFFFF_FFF8, 0, 32'h0, 0, 0), 32'h1F8, 1, 32'h0, 0);
        add(mk(1, 0, 0, 32'h0, 1, 32'h40, 0, 0), 32'h40, 1, 32'h0, 0);
        add(mk(1, 1, 0, 32'h0, 0, 32'h0, 1, 0), 32'h100, 0, 32'h40, 0);
        add(id, 32'h100, 1, 32'h40, 0);
        add(id, 32'h104, 1, 32'h40, 0);
        add(mk(1, 0, 0, 32'h0, 0, 32'h0, 0, 1), 32'h40, 1, 32'h40, 0);
        add(id, 32'h44, 1, 32'h40, 0);
        add(mk(1, 0, 0, 32'h0, 1, 32'h202, 0, 0), 32'h100, 0, 32'h44, 1);
        add(id, 32'h100, 1, 32'h44, 0);
        add(id, 32'h104, 1, 32'h44, 0);
        add(mk(1, 0, 1, 32'h6, 0, 32'h0, 0, 0), 32'h100, 0, 32'h104, 1);
        add(id, 32'h100, 1, 32'h104, 0);
        add(mk(1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 0), 32'hFFFF_FFFC, 1, 32'h104, 0);
        add(id, 32'h0, 1, 32'h104, 0);
        add(mk(1, 1, 0, 32'h0, 0, 32'h0, 0, 0), 32'h0, 1, 32'h104, 0);
        add(id, 32'h4, 1, 32'h104, 0);
        add(mk(0, 1, 1, 32'h8, 1, 32'h300, 1, 1), 32'h0, 0, 32'h0, 0);
        add(id, 32'h0, 1, 32'h0, 0);

        foreach (vq[i]) begin
            step(vq[i].in);
            check($sformatf("vec%0d_pc", i), pc, vq[i].pc);
            check($sformatf("vec%0d_valid", i), 32'(pc_valid), 32'(vq[i].valid));
            check($sformatf("vec%0d_epc", i), epc, vq[i].epc);
            check($sformatf("vec%0d_misalign", i), 32'(misalign), 32'(vq[i].mis));
        end

`ifdef PC_SEQ_RAS_EN
        begin
            logic [31:0] ret_exp [4];
            ret_exp = '{32'h4004, 32'h3004, 32'h2004, 32'h1004};
            for (int i = 0; i < 5; i++) begin
                x = mk(1, 0, 0, 32'h0, 1, 32'((i + 1) << 12), 0, 0);
                x.call = 1'b1;
                step(x);
            end
            for (int i = 0; i < 4; i++) begin
                x = id; x.ret = 1'b1;
                step(x);
                check($sformatf("ras_ret%0d_pc", i), pc, ret_exp[i]);
                check($sformatf("ras_ret%0d_err", i), 32'(ras_err), 32'h0);
            end
            x = id; x.ret = 1'b1;
            step(x);
            check("ras_underflow_pc", pc, 32'h1008);
            check("ras_underflow_err", 32'(ras_err), 32'h1);
            step(id);
            check("ras_err_pulse_clear", 32'(ras_err), 32'h0);
        end
`endif

        step(rs);
        step(rs);
        for (int n = 0; n < 3000; n++) begin
            x.rst_n = ($urandom_range(0, 99) != 0);
            x.stall = ($urandom_range(0, 3) == 0);
            x.br    = ($urandom_range(0, 4) == 0);
            x.off   = 32'($urandom_range(0, 511)) - 32'd256;
            if ($urandom_range(0, 7) != 0) x.off[1:0] = 2'b00;
            x.jmp   = ($urandom_range(0, 5) == 0);
            x.tgt   = $urandom;
            if ($urandom_range(0, 7) != 0) x.tgt[1:0] = 2'b00;
            x.trap  = ($urandom_range(0, 19) == 0);
            x.tret  = ($urandom_range(0, 9) == 0);
            x.call  = ($urandom_range(0, 5) == 0);
            x.ret   = ($urandom_range(0, 5) == 0);
            step(x);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
